// File: rtl/fuzz_reg_ring_if.sv
// fuzz_reg_ring_if: control/observe bundle between fuzzer
// control and the register ring.
interface fuzz_reg_ring_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] steps;
  logic             stop;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, start, mode, steps, stop,
    input  load_ready, q, busy, done
  );

  modport slave (
    input  load_valid, load_data, start, mode, steps, stop,
    output load_ready, q, busy, done
  );
endinterface

// File: rtl/fuzz_reg_ring.sv
// fuzz_reg_ring: WIDTH-bit feedback register bank stepped a
// programmed number of cycles in hold/rotate/LFSR/increment.
module fuzz_reg_ring #(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 16,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic CLK,
  input logic LSR,
  fuzz_reg_ring_if.slave ctl
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_step_q;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_steps;
  logic [CNT_W-1:0] w_steps_nxt;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_nxt;
  logic             r_busy;
  logic             r_done;
  logic             w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);

  // one feedback step of the bank under the latched mode
  always_comb begin
    w_step_q = r_q;
    unique case (r_mode)
      2'd0: w_step_q = r_q;
      2'd1: w_step_q = (r_q << 1) | (r_q >> (WIDTH - 1));
      2'd2: w_step_q = (r_q << 1) | WIDTH'(w_fb);
      2'd3: w_step_q = r_q + WIDTH'(1);
    endcase
  end

  // next-state and datapath decisions for IDLE/RUN/DONE
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_steps_nxt = r_steps;
    unique case (r_state)
      ST_IDLE: begin
        if (ctl.load_valid) begin
          w_q_nxt = ctl.load_data;
        end else if (ctl.start) begin
          if (ctl.steps == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
            w_mode_nxt  = ctl.mode;
            w_steps_nxt = ctl.steps;
            w_cnt_nxt   = '0;
          end
        end
      end
      ST_RUN: begin
        if (ctl.stop) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_q_nxt   = w_step_q;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_cnt_nxt == r_steps) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // state, bank and registered status outputs
  always_ff @(posedge CLK or posedge LSR) begin
    if (LSR) begin
      r_state <= ST_IDLE;
      r_q     <= RESET_VAL;
      r_cnt   <= '0;
      r_steps <= '0;
      r_mode  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
      r_steps <= w_steps_nxt;
      r_mode  <= w_mode_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign ctl.q          = r_q;
  assign ctl.busy       = r_busy;
  assign ctl.done       = r_done;
  assign ctl.load_ready = (r_state == ST_IDLE);

endmodule
